// File: rtl/afifo_test_pkg.sv
// Shared definitions for the AFIFO test producer and its consumer-side checker.
package afifo_test_pkg;

  // Producer FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 12;

  // Next value of the test sequence. A pending skip advances by two so the
  // consumer's checker sees exactly one missing value. Callers truncate the
  // result to their data width, which gives the modulo-2**Width wrap.
  function automatic logic [31:0] next_seq(input logic [31:0] val, input logic skip);
    logic [31:0] res;
    if (skip) begin
      res = val + 32'd2;
    end else begin
      res = val + 32'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/afifo_stall_watchdog.sv
// Stall watchdog: counts consecutive cycles where a request is held without
// acknowledge and raises a sticky trip flag once the count reaches LIMIT.
// LIMIT = 0 disables the watchdog entirely.
module afifo_stall_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ack,
  output logic trip
);

  localparam int SW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [SW-1:0] LIM = SW'(LIMIT);

  logic [SW-1:0] scnt_q, scnt_d;
  logic          trip_q, trip_d;
  logic          stall_s;

  assign stall_s = req & ~ack;
  assign trip    = trip_q;

  // Next-state for the saturating stall counter and the sticky trip flag
  always_comb begin
    scnt_d = scnt_q;
    trip_d = trip_q;
    if (LIMIT == 0) begin
      scnt_d = '0;
      trip_d = 1'b0;
    end else if (!stall_s) begin
      scnt_d = '0;
    end else begin
      if (scnt_q != LIM) begin
        scnt_d = scnt_q + SW'(1);
      end else begin
        scnt_d = scnt_q;
      end
      if (scnt_d == LIM) begin
        trip_d = 1'b1;
      end else begin
        trip_d = trip_q;
      end
    end
  end

  // Watchdog state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt_q <= '0;
      trip_q <= 1'b0;
    end else begin
      scnt_q <= scnt_d;
      trip_q <= trip_d;
    end
  end

endmodule

// File: rtl/afifo_seq_producer.sv
// Write-side source for the AFIFO consumer test: emits a gap-free incrementing
// sequence in bursts separated by idle gaps, honours wok backpressure, supports
// single-shot skip injection and flags prolonged stalls.
module afifo_seq_producer
  import afifo_test_pkg::*;
#(
  parameter int Width      = DEFAULT_WIDTH,
  parameter int StartValue = 0,
  parameter int BurstLen   = 16,
  parameter int GapLen     = 4,
  parameter int StallLimit = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             inject,
  input  logic             wok,
  output logic             w,
  output logic [Width-1:0] wd,
  output logic [31:0]      sent,
  output logic             stall_err
);

  localparam int BW = (BurstLen > 1) ? $clog2(BurstLen) : 1;
  localparam int GW = (GapLen > 0) ? $clog2(GapLen + 1) : 1;
  localparam logic [BW-1:0]    BEAT_LAST = BW'(BurstLen - 1);
  localparam logic [GW-1:0]    GAP_LAST  = (GapLen > 0) ? GW'(GapLen - 1) : GW'(0);
  localparam logic [Width-1:0] WD_RST    = Width'(StartValue);

  state_e           state_q, state_d;
  logic             w_q, w_d;
  logic [Width-1:0] wd_q, wd_d;
  logic [31:0]      sent_q, sent_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             inject_pend_q, inject_pend_d;
  logic             xfer_s;

  // A word moves only when a request meets available space
  assign xfer_s = w_q & wok;

  // FSM next state, burst/gap counters and data/count advance
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    gap_d         = gap_q;
    wd_d          = wd_q;
    sent_d        = sent_q;
    // A new pulse always leaves a pending skip; pulses while pending merge
    inject_pend_d = (inject_pend_q & ~xfer_s) | inject;

    if (xfer_s) begin
      wd_d   = Width'(next_seq(32'(wd_q), inject_pend_q));
      sent_d = sent_q + 32'd1;
    end else begin
      wd_d   = wd_q;
      sent_d = sent_q;
    end

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = BURST;
        end else begin
          state_d = IDLE;
        end
      end
      BURST: begin
        if (xfer_s) begin
          if (beat_q == BEAT_LAST) begin
            beat_d = '0;
            if (GapLen > 0) begin
              state_d = GAP;
              gap_d   = '0;
            end else if (en) begin
              state_d = BURST;
            end else begin
              state_d = IDLE;
            end
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end else begin
          beat_d = beat_q;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          if (en) begin
            state_d = BURST;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
        gap_d   = '0;
      end
    endcase

    // Request is a registered decode of the upcoming state
    w_d = (state_d == BURST);
  end

  // Producer state registers; the sequence restarts at StartValue on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      w_q           <= 1'b0;
      wd_q          <= WD_RST;
      sent_q        <= 32'd0;
      beat_q        <= '0;
      gap_q         <= '0;
      inject_pend_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      w_q           <= w_d;
      wd_q          <= wd_d;
      sent_q        <= sent_d;
      beat_q        <= beat_d;
      gap_q         <= gap_d;
      inject_pend_q <= inject_pend_d;
    end
  end

  afifo_stall_watchdog #(
    .LIMIT(StallLimit)
  ) u_watchdog (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (w_q),
    .ack  (wok),
    .trip (stall_err)
  );

  assign w    = w_q;
  assign wd   = wd_q;
  assign sent = sent_q;

endmodule
